// File: rtl/branch_stack_sequencer.sv
// Stack sequencer for CALL / RET / RTI / interrupt entry: owns SP and the data-memory request channel.
// Optional STACK_GUARD_EN macro enables overflow/underflow trapping (stack_err); default build has no checks.
module branch_stack_sequencer #(
  parameter logic [7:0] SP_RESET    = 8'hFF,
  parameter logic [7:0] INTR_VEC    = 8'h00,
  parameter logic [7:0] STACK_LIMIT = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_target,
  input  logic [7:0] ret_pc,
  input  logic [3:0] flags_in,
  input  logic       intr_req,
  output logic       intr_ack,
  output logic       busy,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       pc_load,
  output logic [7:0] pc_value,
  output logic       flags_load,
  output logic [3:0] flags_value,
  output logic [7:0] sp,
  output logic       stack_err
);

`ifdef STACK_GUARD_EN
  localparam logic GUARD_EN = 1'b1;
`else
  localparam logic GUARD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH_PC, S_PUSH_FLG, S_POP_FLG, S_POP_PC, S_VEC_RD, S_DONE
  } state_t;

  typedef enum logic [1:0] {K_CALL, K_RET, K_RTI, K_INTR} kind_t;

  state_t     state_q;
  kind_t      kind_q;
  logic [7:0] sp_q;
  logic [7:0] target_q;
  logic [3:0] flags_q;
  logic       intr_ack_q;
  logic       busy_q;
  logic       mem_req_q;
  logic       mem_we_q;
  logic [7:0] mem_addr_q;
  logic [7:0] mem_wdata_q;
  logic       pc_load_q;
  logic [7:0] pc_value_q;
  logic       flags_load_q;
  logic [3:0] flags_value_q;
  logic       stack_err_q;

  logic [7:0] sp_dec_s;
  logic [7:0] sp_inc_s;
  logic [7:0] sp_inc2_s;
  logic       push_bad_now_s;
  logic       push_bad_next_s;
  logic       pop_bad_now_s;
  logic       pop_bad_next_s;

  // "now" checks apply at acceptance; "next" checks apply to the second access of a sequence, after SP moves
  always_comb begin
    sp_dec_s        = sp_q - 8'd1;
    sp_inc_s        = sp_q + 8'd1;
    sp_inc2_s       = sp_q + 8'd2;
    push_bad_now_s  = GUARD_EN && (sp_q < STACK_LIMIT);
    push_bad_next_s = GUARD_EN && (sp_dec_s < STACK_LIMIT);
    pop_bad_now_s   = GUARD_EN && (sp_q == 8'hFF);
    pop_bad_next_s  = GUARD_EN && (sp_inc_s == 8'hFF);
  end

  // Sequencer FSM with all outputs registered; requests change only on the edge that consumes mem_ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      kind_q        <= K_CALL;
      sp_q          <= SP_RESET;
      target_q      <= 8'h00;
      flags_q       <= 4'h0;
      intr_ack_q    <= 1'b0;
      busy_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 8'h00;
      mem_wdata_q   <= 8'h00;
      pc_load_q     <= 1'b0;
      pc_value_q    <= 8'h00;
      flags_load_q  <= 1'b0;
      flags_value_q <= 4'h0;
      stack_err_q   <= 1'b0;
    end else begin
      intr_ack_q   <= 1'b0;
      pc_load_q    <= 1'b0;
      flags_load_q <= 1'b0;
      stack_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (intr_req) begin
            intr_ack_q <= 1'b1;
            kind_q     <= K_INTR;
            flags_q    <= flags_in;
            if (push_bad_now_s) begin
              stack_err_q <= 1'b1;
            end else begin
              state_q     <= S_PUSH_PC;
              busy_q      <= 1'b1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= sp_q;
              mem_wdata_q <= ret_pc;
            end
          end else if (cmd_valid && (cmd_op == 2'b00)) begin
            kind_q   <= K_CALL;
            target_q <= cmd_target;
            if (push_bad_now_s) begin
              stack_err_q <= 1'b1;
            end else begin
              state_q     <= S_PUSH_PC;
              busy_q      <= 1'b1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= sp_q;
              mem_wdata_q <= ret_pc;
            end
          end else if (cmd_valid && ((cmd_op == 2'b01) || (cmd_op == 2'b10))) begin
            kind_q <= (cmd_op == 2'b01) ? K_RET : K_RTI;
            if (pop_bad_now_s) begin
              stack_err_q <= 1'b1;
            end else begin
              state_q    <= (cmd_op == 2'b01) ? S_POP_PC : S_POP_FLG;
              busy_q     <= 1'b1;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= sp_inc_s;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_PUSH_PC: begin
          if (mem_ack) begin
            sp_q <= sp_dec_s;
            if (kind_q == K_INTR) begin
              if (push_bad_next_s) begin
                stack_err_q <= 1'b1;
                mem_req_q   <= 1'b0;
                mem_we_q    <= 1'b0;
                busy_q      <= 1'b0;
                state_q     <= S_IDLE;
              end else begin
                state_q     <= S_PUSH_FLG;
                mem_addr_q  <= sp_dec_s;
                mem_wdata_q <= {4'b0000, flags_q};
              end
            end else begin
              mem_req_q  <= 1'b0;
              mem_we_q   <= 1'b0;
              pc_value_q <= target_q;
              pc_load_q  <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end
        S_PUSH_FLG: begin
          if (mem_ack) begin
            sp_q       <= sp_dec_s;
            mem_we_q   <= 1'b0;
            mem_addr_q <= INTR_VEC;
            state_q    <= S_VEC_RD;
          end
        end
        S_VEC_RD: begin
          if (mem_ack) begin
            mem_req_q  <= 1'b0;
            pc_value_q <= mem_rdata;
            pc_load_q  <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_POP_FLG: begin
          if (mem_ack) begin
            sp_q    <= sp_inc_s;
            flags_q <= mem_rdata[3:0];
            if (pop_bad_next_s) begin
              stack_err_q <= 1'b1;
              mem_req_q   <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              mem_addr_q <= sp_inc2_s;
              state_q    <= S_POP_PC;
            end
          end
        end
        S_POP_PC: begin
          if (mem_ack) begin
            sp_q       <= sp_inc_s;
            mem_req_q  <= 1'b0;
            pc_value_q <= mem_rdata;
            pc_load_q  <= 1'b1;
            if (kind_q == K_RTI) begin
              flags_load_q  <= 1'b1;
              flags_value_q <= flags_q;
            end
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign intr_ack    = intr_ack_q;
  assign busy        = busy_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign pc_load     = pc_load_q;
  assign pc_value    = pc_value_q;
  assign flags_load  = flags_load_q;
  assign flags_value = flags_value_q;
  assign sp          = sp_q;
  assign stack_err   = stack_err_q & GUARD_EN;

endmodule
